// File: rtl/dkong_col_mix.sv
// Colour mixer: merges tile and sprite pixels, applies the CPU palette bank and
// looks up two downloadable 256x4 active-low palette PROM images into 3-3-2 RGB.
module dkong_col_mix #(
    parameter logic [7:0] PROM_HI_SEL = 8'hF2,
    parameter logic [7:0] PROM_LO_SEL = 8'hF3
) (
    input  logic        CLK_24M,
    input  logic        I_RESETn,
    input  logic        CLK_EN,
    input  logic [9:0]  I_H_CNT,
    input  logic [1:0]  I_VID,
    input  logic [3:0]  I_COL,
    input  logic [5:0]  I_OBJ,
    input  logic        I_CMPBLK,
    input  logic [1:0]  I_PAL_BANK,
    input  logic [15:0] DL_ADDR,
    input  logic        DL_WR,
    input  logic [7:0]  DL_DATA,
    output logic [2:0]  O_R,
    output logic [2:0]  O_G,
    output logic [1:0]  O_B,
    output logic        O_BLANK
);

    logic       pix_en;
    logic [1:0] bank_reg;
    logic [5:0] sel_reg;
    logic [5:0] sel_next;
    logic       blk1_reg;
    logic [7:0] pal_a;
    logic [3:0] hi_rd;
    logic [3:0] lo_rd;

    // Only the half-pixel phase and the low data nibble matter here.
    logic unused_bits;
    assign unused_bits = &{1'b0, I_H_CNT[9:1], DL_DATA[7:4]};

    assign pix_en = CLK_EN & I_H_CNT[0];

    always_comb begin
        sel_next = {I_COL, I_VID};
        if (I_CMPBLK) begin
            sel_next = 6'h00;
        end else if (I_OBJ[1:0] != 2'b00) begin
            sel_next = I_OBJ;
        end
    end

    // Bank only moves during blank so a CPU write never splits a line.
    always_ff @(posedge CLK_24M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            sel_reg  <= 6'h00;
            blk1_reg <= 1'b1;
            bank_reg <= 2'b00;
        end else if (pix_en) begin
            sel_reg  <= sel_next;
            blk1_reg <= I_CMPBLK;
            if (I_CMPBLK) begin
                bank_reg <= I_PAL_BANK;
            end
        end
    end

    assign pal_a = {bank_reg, sel_reg};

    // gi=0 is the high-nibble image, gi=1 the low-nibble image. Read-before-write
    // ordering in one block gives old data on a same-address collision.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_prom
            localparam logic [7:0] SEL = (gi == 0) ? PROM_HI_SEL : PROM_LO_SEL;
            logic [3:0] mem [0:255];
            logic [3:0] rd_reg;
            logic       we;

            assign we = DL_WR && (DL_ADDR[15:8] == SEL);

            always_ff @(posedge CLK_24M) begin
                if (we) begin
                    mem[DL_ADDR[7:0]] <= DL_DATA[3:0];
                end
                rd_reg <= mem[pal_a];
            end
        end
    endgenerate

    assign hi_rd = gen_prom[0].rd_reg;
    assign lo_rd = gen_prom[1].rd_reg;

    always_ff @(posedge CLK_24M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            O_R     <= 3'b000;
            O_G     <= 3'b000;
            O_B     <= 2'b00;
            O_BLANK <= 1'b1;
        end else if (pix_en) begin
            if (blk1_reg) begin
                O_R     <= 3'b000;
                O_G     <= 3'b000;
                O_B     <= 2'b00;
                O_BLANK <= 1'b1;
            end else begin
                O_R     <= ~hi_rd[3:1];
                O_G     <= {~hi_rd[0], ~lo_rd[3:2]};
                O_B     <= ~lo_rd[1:0];
                O_BLANK <= 1'b0;
            end
        end
    end

endmodule
